// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: CPU-side request/response bundle for mem_access_unit.
// master = CPU (issues requests, consumes responses), slave = the access unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU load/store front-end for a word-wide RAM with combinational read.
// Sub-word stores are done as read-modify-write (RD then WR).
// Macro MAU_MISALIGN_CHECK_EN: when defined, misaligned halfword/word accesses get an error
// response with no memory effect; when undefined, the low address bits are forced to zero.
module mem_access_unit #(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave cpu,
  output logic [31:0]      address,
  output logic [31:0]      writedata,
  input  logic [31:0]      readdata,
  output logic             write_en,
  output logic             read_en
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRd   = 2'd1;
  localparam logic [1:0] StWr   = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        write_q, signed_q, err_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] idx_q, wdata_q, rmw_q, rdata_q;

  logic        accept, misalign;
  logic [31:0] eff_addr;

  // Extract the addressed lane from a RAM word and zero/sign-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sext & b[7]}}, b};
      2'b01:   r = {{16{sext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the old word with the right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] data,
                                              input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00: r[{lane, 3'b000} +: 8] = data[7:0];
      2'b01: begin
        if (lane[1]) r[31:16] = data[15:0];
        else         r[15:0]  = data[15:0];
      end
      default: r = data;
    endcase
    return r;
  endfunction

  assign accept = cpu.req_valid && (state_q == StIdle) && !reset;

  // Effective address and misalignment decision for the incoming request.
  always_comb begin
    eff_addr = cpu.req_addr;
    misalign = 1'b0;
`ifdef MAU_MISALIGN_CHECK_EN
    misalign = ((cpu.req_size == 2'b01) && cpu.req_addr[0]) ||
               (cpu.req_size[1] && (cpu.req_addr[1:0] != 2'b00));
`else
    if (cpu.req_size == 2'b01) eff_addr[0] = 1'b0;
    else if (cpu.req_size[1])  eff_addr[1:0] = 2'b00;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (misalign)                                state_d = StResp;
          else if (cpu.req_write && cpu.req_size[1])   state_d = StWr;
          else                                         state_d = StRd;
        end
      end
      StRd:    state_d = write_q ? StWr : StResp;
      StWr:    state_d = StResp;
      default: if (cpu.resp_ready) state_d = StIdle;
    endcase
  end

  // State and request/data registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      lane_q   <= 2'b00;
      idx_q    <= '0;
      wdata_q  <= '0;
      rmw_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= cpu.req_write;
        signed_q <= cpu.req_signed;
        size_q   <= cpu.req_size;
        lane_q   <= eff_addr[1:0];
        idx_q    <= (eff_addr - MEM_BASE) >> 2;
        wdata_q  <= cpu.req_wdata;
        rdata_q  <= '0;
        err_q    <= misalign;
      end
      if (state_q == StRd) begin
        if (write_q) rmw_q   <= readdata;
        else         rdata_q <= load_extract(readdata, lane_q, size_q, signed_q);
      end
    end
  end

  // Outputs decoded from the current state; everything idles at zero.
  always_comb begin
    cpu.req_ready  = (state_q == StIdle) && !reset;
    cpu.resp_valid = (state_q == StResp);
    cpu.resp_rdata = (state_q == StResp) ? rdata_q : '0;
    cpu.resp_err   = (state_q == StResp) ? err_q : 1'b0;
    read_en        = (state_q == StRd);
    write_en       = (state_q == StWr);
    address        = (read_en || write_en) ? idx_q : '0;
    writedata      = write_en ? store_merge(rmw_q, wdata_q, lane_q, size_q) : '0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: random + directed load/store traffic against a word-array reference
// model; responses are checked by a scoreboard monitor, RAM strobes by a protocol monitor.
module tb_mem_access_unit;
  localparam logic [31:0] MEM_BASE = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] address, writedata, readdata;
  logic        write_en, read_en;

  mem_access_unit_if cpu ();

  mem_access_unit #(.MEM_BASE(MEM_BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .write_en  (write_en),
    .read_en   (read_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side RAM with a preload port used only while the DUT is idle.
  logic [31:0] ram [64];
  logic [31:0] ref_mem [64];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  assign readdata = ram[address[5:0]];

  always @(posedge clk) begin
    if (write_en)   ram[address[5:0]] <= writedata;
    else if (pl_en) ram[pl_idx] <= pl_val;
  end

  int          total = 0;
  int          bad = 0;
  logic [32:0] sb_q [$];
  int          rd_cnt = 0, wr_cnt = 0, cyc = 0, rd_cyc = 0, wr_cyc = 0;
  logic [31:0] rd_addr, wr_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Per-cycle RAM strobe bookkeeping and mutual exclusion check.
  task automatic prot_mon();
    forever begin
      @(negedge clk);
      cyc++;
      check("rd_wr_exclusive", {31'd0, read_en & write_en}, 32'd0);
      if (read_en)  begin rd_cnt++; rd_cyc = cyc; rd_addr = address; end
      if (write_en) begin wr_cnt++; wr_cyc = cyc; wr_addr = address; end
    end
  endtask

  // Scoreboard: pop and compare on every response handshake.
  task automatic sb_mon();
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!reset && cpu.resp_valid && cpu.resp_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("resp_rdata", cpu.resp_rdata, e[32:1]);
          check("resp_err", {31'd0, cpu.resp_err}, {31'd0, e[0]});
        end
      end
    end
  endtask

  task automatic preload(input int i, input logic [31:0] v);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = 6'(i); pl_val = v;
    ref_mem[i] = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request, predict its response from the reference model, hold resp_ready low
  // for 'stall' cycles once the response appears.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int stall);
    logic [31:0] eff, idx, word, mask, v, exp_rd;
    logic        mis;
    int          sh, lat, exp_lat, rd0, wr0, exp_nrd, exp_nwr;
    bit          got;
    eff = a;
    mis = 1'b0;
`ifdef MAU_MISALIGN_CHECK_EN
    mis = ((sz == 2'b01) && (a % 2 != 0)) || ((sz >= 2'b10) && (a % 4 != 0));
`else
    if (sz == 2'b01)      eff = a - (a % 2);
    else if (sz >= 2'b10) eff = a - (a % 4);
`endif
    idx = (eff - MEM_BASE) / 4;
    sh = 8 * int'(eff % 4);
    case (sz)
      2'b00:   mask = 32'h0000_00FF;
      2'b01:   mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    word = ref_mem[idx[5:0]];
    exp_rd = 32'd0;
    if (mis) begin
      exp_lat = 1; exp_nrd = 0; exp_nwr = 0;
    end else if (!w) begin
      v = (word >> sh) & mask;
      if (sg && ((v & ((mask >> 1) + 32'd1)) != 32'd0)) v = v | ~mask;
      exp_rd = v;
      exp_lat = 2; exp_nrd = 1; exp_nwr = 0;
    end else begin
      ref_mem[idx[5:0]] = (word & ~(mask << sh)) | ((wd & mask) << sh);
      exp_lat = (sz >= 2'b10) ? 2 : 3;
      exp_nrd = (sz >= 2'b10) ? 0 : 1;
      exp_nwr = 1;
    end
    sb_q.push_back({exp_rd, mis});
    rd0 = rd_cnt;
    wr0 = wr_cnt;

    @(posedge clk); #1;
    cpu.req_valid = 1'b1; cpu.req_write = w; cpu.req_size = sz; cpu.req_signed = sg;
    cpu.req_addr = a; cpu.req_wdata = wd; cpu.resp_ready = (stall == 0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cpu.req_ready) begin got = 1; break; end
    end
    @(posedge clk); #1;
    cpu.req_valid = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: got req_ready=0 want 1 addr %h", a);
      void'(sb_q.pop_back());
      return;
    end
    lat = 1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cpu.resp_valid) begin got = 1; break; end
      @(posedge clk); #1;
      lat++;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL resp_timeout: got no resp_valid want latency %0d", exp_lat);
      void'(sb_q.pop_back());
      cpu.resp_ready = 1'b1;
      return;
    end
    check("latency", lat, exp_lat);
    for (int k = 0; k < stall; k++) begin
      check("stall_valid", {31'd0, cpu.resp_valid}, 32'd1);
      check("stall_req_ready", {31'd0, cpu.req_ready}, 32'd0);
      check("stall_rdata", cpu.resp_rdata, exp_rd);
      check("stall_err", {31'd0, cpu.resp_err}, {31'd0, mis});
      @(posedge clk); #1;
      if (k == stall - 1) cpu.resp_ready = 1'b1;
      @(negedge clk);
    end
    check("n_read_en", rd_cnt - rd0, exp_nrd);
    check("n_write_en", wr_cnt - wr0, exp_nwr);
    if (exp_nrd != 0) check("rd_addr", rd_addr, idx);
    if (exp_nwr != 0) begin
      check("wr_addr", wr_addr, idx);
      check("ram_word", ram[idx[5:0]], ref_mem[idx[5:0]]);
    end
    if (exp_nrd != 0 && exp_nwr != 0) check("rmw_order", wr_cyc, rd_cyc + 1);
  endtask

  initial begin
    int w0;
    reset = 1'b1;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    cpu.req_valid = 1'b0; cpu.req_write = 1'b0; cpu.req_size = 2'b00; cpu.req_signed = 1'b0;
    cpu.req_addr = '0; cpu.req_wdata = '0; cpu.resp_ready = 1'b1;
    fork
      prot_mon();
      sb_mon();
    join_none

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, cpu.req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, cpu.resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, cpu.resp_err}, 32'd0);
    check("rst_resp_rdata", cpu.resp_rdata, 32'd0);
    check("rst_read_en", {31'd0, read_en}, 32'd0);
    check("rst_write_en", {31'd0, write_en}, 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_writedata", writedata, 32'd0);
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {31'd0, cpu.req_ready}, 32'd1);

    // Word load.
    preload(3, 32'hDEAD_BEEF);
    run_req(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'd0, 0);
    // Signed and unsigned byte load.
    preload(0, 32'h0000_8000);
    run_req(1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'd0, 0);
    run_req(1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'd0, 0);
    // Byte store as read-modify-write.
    preload(2, 32'h1122_3344);
    run_req(1'b1, 2'b00, 1'b0, 32'h0000_000A, 32'h0000_00AA, 0);
    check("byte_store_word2", ram[2], 32'h11AA_3344);
    // Misaligned halfword load.
    preload(0, 32'hCAFE_1234);
    run_req(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'd0, 0);
    // Back-pressure.
    preload(7, 32'h8765_4321);
    run_req(1'b0, 2'b10, 1'b0, 32'h0000_001C, 32'd0, 5);

    // Reset in RD of a byte store.
    preload(5, 32'h5566_7788);
    w0 = wr_cnt;
    @(posedge clk); #1;
    cpu.req_valid = 1'b1; cpu.req_write = 1'b1; cpu.req_size = 2'b00; cpu.req_signed = 1'b0;
    cpu.req_addr = 32'h0000_0015; cpu.req_wdata = 32'h0000_00AA; cpu.resp_ready = 1'b1;
    @(negedge clk);
    check("rst_test_req_ready", {31'd0, cpu.req_ready}, 32'd1);
    @(posedge clk); #1;
    cpu.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_test_in_rd", {31'd0, read_en}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_test_ready_low", {31'd0, cpu.req_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_test_ready_after", {31'd0, cpu.req_ready}, 32'd1);
    check("rst_test_no_resp", {31'd0, cpu.resp_valid}, 32'd0);
    repeat (4) @(negedge clk);
    check("rst_test_no_write", wr_cnt - w0, 32'd0);
    check("rst_test_ram", ram[5], 32'h5566_7788);

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 255)), $urandom, int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    check("sb_leftover", sb_q.size(), 32'd0);
    for (int i = 0; i < 64; i++) check("ram_final", ram[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
